// File: rtl/prach_ditfft3_combine.sv
// Radix-3 DIT output combiner: turns (x0, s=x1+x2, d=x1-x2) into X0/X1/X2, scaled by 1/2 and emitted as a 3-cycle burst.
// Build option: define PRACH_DITFFT3_COMBINE_SAT_EN to saturate results to 18 bits instead of wrapping.
module prach_ditfft3_combine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] din_dr,
  input  logic [17:0] din_di,
  input  logic        din_dv,
  input  logic        sync_in,
  output logic [17:0] dout_dr,
  output logic [17:0] dout_di,
  output logic        dout_dv,
  output logic        sync_out
);
  localparam int STAGES = 3;
  localparam logic signed [39:0] C_R3 = 40'sd113512;

  typedef enum logic [1:0] {PH_X0, PH_S, PH_D} phase_t;

  phase_t phase_q, phase_d;
  logic   cap_x0, cap_s, done;

  logic signed [17:0] x0r_q, x0i_q, sr_q, si_q;
  logic               spend_q;
  logic signed [17:0] gx0r_q, gx0i_q, gsr_q, gsi_q, gdr_q, gdi_q;
  logic signed [39:0] v0r_q, v0i_q, v1r_q, v1i_q, v2r_q, v2i_q;
  logic signed [39:0] v0r_d, v0i_d, v1r_d, v1i_d, v2r_d, v2i_d;
  logic [17:0]        r0r_q, r0i_q, r1r_q, r1i_q, r2r_q, r2i_q;
  logic [35:0]        b1_q, b2_q;
  logic [1:0]         rem_q;
  logic [STAGES:0]    vld_pipe_q, syn_pipe_q;

  // A synced beat always restarts the group, dropping any partial one.
  always_comb begin
    phase_d = phase_q;
    cap_x0  = 1'b0;
    cap_s   = 1'b0;
    done    = 1'b0;
    if (din_dv) begin
      if (sync_in || phase_q == PH_X0) begin
        cap_x0  = 1'b1;
        phase_d = PH_S;
      end else if (phase_q == PH_S) begin
        cap_s   = 1'b1;
        phase_d = PH_D;
      end else begin
        done    = 1'b1;
        phase_d = PH_X0;
      end
    end
  end

  always_comb begin
    logic signed [39:0] x0r, x0i, sr, si, dr, di, base_r, base_i, rot_r, rot_i;
    x0r = gx0r_q; x0i = gx0i_q; sr = gsr_q; si = gsi_q; dr = gdr_q; di = gdi_q;
    base_r = (x0r <<< 17) - (sr <<< 16);
    base_i = (x0i <<< 17) - (si <<< 16);
    rot_r  = C_R3 * di;
    rot_i  = C_R3 * dr;
    v0r_d  = (x0r + sr) <<< 17;
    v0i_d  = (x0i + si) <<< 17;
    v1r_d  = base_r + rot_r;
    v1i_d  = base_i - rot_i;
    v2r_d  = base_r - rot_r;
    v2i_d  = base_i + rot_i;
  end

  function automatic logic [17:0] rnd_red(input logic signed [39:0] v);
    logic signed [39:0] t;
    t = (v + 40'sd131072) >>> 18;
`ifdef PRACH_DITFFT3_COMBINE_SAT_EN
    if (t > 40'sd131071)       rnd_red = 18'h1ffff;
    else if (t < -40'sd131072) rnd_red = 18'h20000;
    else                       rnd_red = t[17:0];
`else
    rnd_red = t[17:0];
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_X0;
      x0r_q <= '0; x0i_q <= '0; sr_q <= '0; si_q <= '0; spend_q <= 1'b0;
      gx0r_q <= '0; gx0i_q <= '0; gsr_q <= '0; gsi_q <= '0; gdr_q <= '0; gdi_q <= '0;
      v0r_q <= '0; v0i_q <= '0; v1r_q <= '0; v1i_q <= '0; v2r_q <= '0; v2i_q <= '0;
      r0r_q <= '0; r0i_q <= '0; r1r_q <= '0; r1i_q <= '0; r2r_q <= '0; r2i_q <= '0;
      b1_q <= '0; b2_q <= '0; rem_q <= '0;
      vld_pipe_q <= '0; syn_pipe_q <= '0;
      dout_dr <= '0; dout_di <= '0; dout_dv <= 1'b0; sync_out <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (cap_x0) begin
        x0r_q   <= din_dr;
        x0i_q   <= din_di;
        spend_q <= sync_in;
      end
      if (cap_s) begin
        sr_q <= din_dr;
        si_q <= din_di;
      end
      if (done) begin
        gx0r_q <= x0r_q; gx0i_q <= x0i_q;
        gsr_q  <= sr_q;  gsi_q  <= si_q;
        gdr_q  <= din_dr; gdi_q <= din_di;
      end
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], done};
      syn_pipe_q <= {syn_pipe_q[STAGES-1:0], done & spend_q};
      if (vld_pipe_q[0]) begin
        v0r_q <= v0r_d; v0i_q <= v0i_d;
        v1r_q <= v1r_d; v1i_q <= v1i_d;
        v2r_q <= v2r_d; v2i_q <= v2i_d;
      end
      if (vld_pipe_q[1]) begin
        r0r_q <= rnd_red(v0r_q); r0i_q <= rnd_red(v0i_q);
        r1r_q <= rnd_red(v1r_q); r1i_q <= rnd_red(v1i_q);
        r2r_q <= rnd_red(v2r_q); r2i_q <= rnd_red(v2i_q);
      end
      // X1/X2 are parked so the next group can reuse the round stage mid-burst.
      if (vld_pipe_q[STAGES]) begin
        dout_dr  <= r0r_q;
        dout_di  <= r0i_q;
        b1_q     <= {r1r_q, r1i_q};
        b2_q     <= {r2r_q, r2i_q};
        rem_q    <= 2'd2;
        dout_dv  <= 1'b1;
        sync_out <= syn_pipe_q[STAGES];
      end else if (rem_q != 2'd0) begin
        {dout_dr, dout_di} <= b1_q;
        b1_q     <= b2_q;
        rem_q    <= rem_q - 2'd1;
        dout_dv  <= 1'b1;
        sync_out <= 1'b0;
      end else begin
        dout_dv  <= 1'b0;
        sync_out <= 1'b0;
      end
    end
  end
endmodule
